// File: rtl/cacheline_mem_adapter.sv
// cacheline_mem_adapter: converts cache line read/write requests into 64-bit bmem bursts
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   dfp_addr/read/write/wdata  line request from the cache (held until dfp_resp)
//   dfp_rdata, dfp_resp      assembled read line, one-cycle completion pulse
//   bmem_addr/read/write/wdata burst command and write beats toward memory
//   bmem_ready               memory accepts a command or beat this cycle
//   bmem_raddr/rdata/rvalid  returning read beats, tagged with their burst address
module cacheline_mem_adapter #(
    parameter int LINE_BITS = 256,
    parameter int BEAT_BITS = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          dfp_addr,
    input  logic                 dfp_read,
    input  logic                 dfp_write,
    input  logic [LINE_BITS-1:0] dfp_wdata,
    output logic [LINE_BITS-1:0] dfp_rdata,
    output logic                 dfp_resp,
    output logic [31:0]          bmem_addr,
    output logic                 bmem_read,
    output logic                 bmem_write,
    output logic [BEAT_BITS-1:0] bmem_wdata,
    input  logic                 bmem_ready,
    input  logic [31:0]          bmem_raddr,
    input  logic [BEAT_BITS-1:0] bmem_rdata,
    input  logic                 bmem_rvalid
);
    localparam int BEATS = LINE_BITS / BEAT_BITS;
    localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [31:0] LINE_MASK = ~32'((LINE_BITS / 8) - 1);

    typedef enum logic [2:0] {IDLE, RD_CMD, RD_DATA, WRITE, RESP} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [31:0]          addr_q, addr_d;
    logic [LINE_BITS-1:0] rdata_q, rdata_d;
    logic                 last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        rdata_d    = rdata_q;
        bmem_read  = 1'b0;
        bmem_write = 1'b0;
        bmem_wdata = '0;
        dfp_resp   = 1'b0;
        last       = cnt_q == CW'(BEATS - 1);
        case (state_q)
            IDLE: begin
                // write wins a simultaneous request; the held read is taken after its RESP
                if (dfp_write || dfp_read) begin
                    addr_d  = dfp_addr & LINE_MASK;
                    cnt_d   = '0;
                    state_d = dfp_write ? WRITE : RD_CMD;
                end
            end
            RD_CMD: begin
                bmem_read = 1'b1;
                if (bmem_ready) state_d = RD_DATA;
            end
            RD_DATA: begin
                // beats tagged with another burst's address belong to someone else
                if (bmem_rvalid && bmem_raddr == addr_q) begin
                    rdata_d[BEAT_BITS*cnt_q +: BEAT_BITS] = bmem_rdata;
                    cnt_d = cnt_q + CW'(1);
                    if (last) state_d = RESP;
                end
            end
            WRITE: begin
                bmem_write = 1'b1;
                bmem_wdata = dfp_wdata[BEAT_BITS*cnt_q +: BEAT_BITS];
                if (bmem_ready) begin
                    cnt_d = cnt_q + CW'(1);
                    if (last) state_d = RESP;
                end
            end
            RESP: begin
                dfp_resp = 1'b1;
                cnt_d    = '0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
        bmem_addr = (bmem_read || bmem_write) ? addr_q : '0;
    end

    assign dfp_rdata = rdata_q;
endmodule

// File: tb/tb_cacheline_mem_adapter.sv
// tb_cacheline_mem_adapter: scoreboard bench for cacheline_mem_adapter
module tb_cacheline_mem_adapter;
    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  dfp_addr;
    logic         dfp_read, dfp_write;
    logic [255:0] dfp_wdata, dfp_rdata;
    logic         dfp_resp;
    logic [31:0]  bmem_addr, bmem_raddr;
    logic         bmem_read, bmem_write, bmem_ready, bmem_rvalid;
    logic [63:0]  bmem_wdata, bmem_rdata;

    typedef struct {logic [31:0] a; logic [63:0] d;} wbeat_t;
    typedef struct {logic [31:0] a; int c;} cmd_t;
    typedef struct {logic [255:0] d; int c;} resp_t;

    wbeat_t wq[$];
    cmd_t   cq[$];
    resp_t  rq[$];
    int     vecs = 0, errs = 0, cyc = 0, n;
    logic [255:0] last_line = '0, line;

    cacheline_mem_adapter dut (
        .clk(clk), .rst(rst),
        .dfp_addr(dfp_addr), .dfp_read(dfp_read), .dfp_write(dfp_write),
        .dfp_wdata(dfp_wdata), .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp),
        .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
        .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
        .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // monitor: compares every DUT-presented event against the scoreboard queues
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (bmem_read || bmem_write) chk("excl", 256'(bmem_read & bmem_write), 256'(0));
            if (bmem_write) begin
                if (wq.size() == 0) chk("unexp_write", 256'(1), 256'(0));
                else begin
                    chk("waddr", 256'(bmem_addr), 256'(wq[0].a));
                    chk("wdata", 256'(bmem_wdata), 256'(wq[0].d));
                    if (bmem_ready) void'(wq.pop_front());
                end
            end
            if (bmem_read && bmem_ready) begin
                if (cq.size() == 0) chk("unexp_read", 256'(1), 256'(0));
                else begin
                    chk("raddr", 256'(bmem_addr), 256'(cq[0].a));
                    if (cq[0].c >= 0) chk("rcmd_cyc", 256'(cyc), 256'(cq[0].c));
                    void'(cq.pop_front());
                end
            end
            if (dfp_resp) begin
                if (rq.size() == 0) chk("unexp_resp", 256'(1), 256'(0));
                else begin
                    chk("rdata", dfp_rdata, rq[0].d);
                    if (rq[0].c >= 0) chk("resp_cyc", 256'(cyc), 256'(rq[0].c));
                    void'(rq.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] ra, input logic [63:0] d);
        bmem_rvalid = 1'b1;
        bmem_raddr  = ra;
        bmem_rdata  = d;
        step();
        bmem_rvalid = 1'b0;
    endtask

    // returns in the first RD_DATA cycle
    task automatic wait_cmd();
        int i;
        for (i = 0; i < 50; i++) begin
            step();
            if (bmem_read) break;
        end
        if (i == 50) chk("cmd_timeout", 256'(1), 256'(0));
        step();
    endtask

    task automatic wait_resp();
        int i;
        for (i = 0; i < 50; i++) begin
            if (dfp_resp) break;
            step();
        end
        if (i == 50) chk("resp_timeout", 256'(1), 256'(0));
    endtask

    task automatic push_line(input logic [31:0] a, input logic [255:0] l);
        for (int b = 0; b < 4; b++) wq.push_back('{a, l[64*b +: 64]});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; dfp_addr = '0; dfp_read = 1'b0; dfp_write = 1'b0; dfp_wdata = '0;
        bmem_ready = 1'b1; bmem_raddr = '0; bmem_rdata = '0; bmem_rvalid = 1'b0;
        repeat (3) step();
        chk("rst_rdata", dfp_rdata, '0);
        chk("rst_outs", 256'({dfp_resp, bmem_read, bmem_write}), 256'(0));
        chk("rst_bus", 256'({bmem_addr, bmem_wdata}), 256'(0));
        rst = 1'b0;
        step();

        // plain read
        n = cyc;
        line = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
        dfp_addr = 32'h0000_1234; dfp_read = 1'b1;
        cq.push_back('{32'h0000_1220, n + 1});
        rq.push_back('{line, n + 6});
        wait_cmd();
        for (int b = 0; b < 4; b++) beat(32'h0000_1220, line[64*b +: 64]);
        wait_resp();
        dfp_read = 1'b0; last_line = line;
        step();

        // plain write; address change mid-burst must not matter
        n = cyc;
        line = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
        dfp_addr = 32'h8000_0040; dfp_wdata = line; dfp_write = 1'b1;
        push_line(32'h8000_0040, line);
        rq.push_back('{last_line, n + 5});
        step(); step();
        dfp_addr = 32'hFFFF_FFFF;
        wait_resp();
        dfp_write = 1'b0;
        step();

        // write with beat 2 stalled three cycles
        n = cyc;
        line = {64'h4444_0000_0000_0004, 64'h3333_0000_0000_0003,
                64'h2222_0000_0000_0002, 64'h1111_0000_0000_0001};
        dfp_addr = 32'h0000_0040; dfp_wdata = line; dfp_write = 1'b1;
        push_line(32'h0000_0040, line);
        rq.push_back('{last_line, n + 8});
        step(); step(); step();
        bmem_ready = 1'b0;
        repeat (3) step();
        bmem_ready = 1'b1;
        wait_resp();
        dfp_write = 1'b0;
        step();

        // simultaneous write and read
        n = cyc;
        line = {64'hF0F0_F0F0_0000_0003, 64'hF0F0_F0F0_0000_0002,
                64'hF0F0_F0F0_0000_0001, 64'hF0F0_F0F0_0000_0000};
        dfp_addr = 32'h0000_0100; dfp_wdata = line; dfp_write = 1'b1; dfp_read = 1'b1;
        push_line(32'h0000_0100, line);
        rq.push_back('{last_line, n + 5});
        wait_resp();
        dfp_write = 1'b0; dfp_addr = 32'h0000_0200;
        line = {64'h0202_0202_0202_0204, 64'h0202_0202_0202_0203,
                64'h0202_0202_0202_0202, 64'h0202_0202_0202_0201};
        cq.push_back('{32'h0000_0200, n + 7});
        rq.push_back('{line, n + 12});
        wait_cmd();
        for (int b = 0; b < 4; b++) beat(32'h0000_0200, line[64*b +: 64]);
        wait_resp();
        dfp_read = 1'b0; last_line = line;
        step();

        // read with a foreign beat interleaved
        n = cyc;
        line = {64'h3000_0000_0000_0040, 64'h3000_0000_0000_0030,
                64'h3000_0000_0000_0020, 64'h3000_0000_0000_0010};
        dfp_addr = 32'h0000_3000; dfp_read = 1'b1;
        cq.push_back('{32'h0000_3000, n + 1});
        rq.push_back('{line, n + 7});
        wait_cmd();
        beat(32'h0000_3000, line[63:0]);
        beat(32'hDEAD_BEE0, 64'hBAD0_BAD0_BAD0_BAD0);
        for (int b = 1; b < 4; b++) beat(32'h0000_3000, line[64*b +: 64]);
        wait_resp();
        dfp_read = 1'b0; last_line = line;
        step();

        // reset after two beats
        n = cyc;
        dfp_addr = 32'h0000_5000; dfp_read = 1'b1;
        cq.push_back('{32'h0000_5000, n + 1});
        wait_cmd();
        beat(32'h0000_5000, 64'h5555_5555_5555_5555);
        beat(32'h0000_5000, 64'h6666_6666_6666_6666);
        rst = 1'b1; dfp_read = 1'b0;
        step();
        chk("mid_rst_rdata", dfp_rdata, '0);
        chk("mid_rst_outs", 256'({dfp_resp, bmem_read, bmem_write}), 256'(0));
        rst = 1'b0;
        step();
        beat(32'h0000_6000, 64'hBAD1_BAD1_BAD1_BAD1);
        chk("idle_rvalid", dfp_rdata, '0);

        // fresh read after reset
        n = cyc;
        line = {64'h6000_0000_0000_0004, 64'h6000_0000_0000_0003,
                64'h6000_0000_0000_0002, 64'h6000_0000_0000_0001};
        dfp_addr = 32'h0000_6008; dfp_read = 1'b1;
        cq.push_back('{32'h0000_6000, n + 1});
        rq.push_back('{line, n + 6});
        wait_cmd();
        for (int b = 0; b < 4; b++) beat(32'h0000_6000, line[64*b +: 64]);
        wait_resp();
        dfp_read = 1'b0;
        repeat (3) step();

        chk("wq_empty", 256'(wq.size()), 256'(0));
        chk("cq_empty", 256'(cq.size()), 256'(0));
        chk("rq_empty", 256'(rq.size()), 256'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/cacheline_mem_adapter.md
Name: cacheline_mem_adapter

Overview:
- Memory-side responder for the cache's downstream (dfp) port.
- Accepts one 256-bit line read or write request from the cache and converts it into a burst transaction on the 64-bit bmem interface.
- Read bursts are assembled into a full line; write lines are split into four beats.
- Returns a single-cycle dfp_resp per completed request, so the cache's writeback-then-refill sequence sees two independent completions.

Parameters:
- LINE_BITS, 256, cacheline width on the dfp side.
- BEAT_BITS, 64, bmem data width. BEATS = LINE_BITS/BEAT_BITS (4) is a derived localparam, not overridable.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- dfp_addr  in  32  line address from cache; bits [4:0] ignored
- dfp_read  in  1  line read request, held high until dfp_resp
- dfp_write  in  1  line write request, held high until dfp_resp
- dfp_wdata  in  256  write line, stable while dfp_write high
- dfp_rdata  out  256  assembled read line
- dfp_resp  out  1  one-cycle completion pulse
- bmem_addr  out  32  burst base address {dfp_addr[31:5],5'b0}
- bmem_read  out  1  burst read command
- bmem_write  out  1  burst write beat valid
- bmem_wdata  out  64  write beat data
- bmem_ready  in  1  memory can accept a command or beat this cycle
- bmem_raddr  in  32  address tag of returning read beats
- bmem_rdata  in  64  read beat data
- bmem_rvalid  in  1  read beat valid

Behaviour:
- Reset values: all outputs 0, dfp_rdata 0, state IDLE, beat counter 0.
- States:
  - IDLE: latch the request address. If dfp_write is high, go to WRITE. Otherwise, if dfp_read is high, go to RD_CMD.
  - RD_CMD: drive bmem_read=1 with bmem_addr. The command is accepted in the first cycle with bmem_ready=1; then go to RD_DATA. If bmem_ready=0, hold the command.
  - RD_DATA: each cycle with bmem_rvalid=1 and bmem_raddr equal to the latched base address, write bmem_rdata into dfp_rdata[64*cnt +: 64] and increment cnt. Beats with a mismatched raddr are ignored. After the 4th accepted beat, go to RESP.
  - WRITE: drive bmem_write=1, bmem_addr, and bmem_wdata = dfp_wdata[64*cnt +: 64]. A beat is consumed and cnt increments only when bmem_ready=1. If bmem_ready=0, the beat is held with the same data. After the 4th consumed beat, go to RESP.
  - RESP: dfp_resp=1 for exactly one cycle, cnt cleared, then IDLE.
- Simultaneous dfp_read and dfp_write in IDLE: the write is serviced first. After its dfp_resp, the still-asserted read is taken on the next IDLE cycle. This gives two distinct dfp_resp pulses.
- Minimum latency:
  - Write: dfp_write high at cycle 0 → beats at cycles 1–4 (ready always high) → dfp_resp at cycle 5.
  - Read: command at cycle 1 → dfp_resp on the cycle after the 4th valid beat.
- IDLE→request acceptance requires one IDLE cycle after RESP. A request still high during the RESP cycle is not re-serviced until the following IDLE cycle.
- dfp_rdata holds its value from RESP until overwritten by the next read's beats. A write does not modify dfp_rdata.
- The address and mode are latched at acceptance. Changes on dfp_addr or dfp_wdata mid-burst have no effect on the address. dfp_wdata is sampled per beat and must stay stable.
- bmem_read and bmem_write are never both high. bmem_write is never high outside WRITE; bmem_read is never high outside RD_CMD.
- rvalid outside RD_DATA is ignored.
- Reset mid-burst: on the next edge, return to IDLE, drop bmem_read and bmem_write, discard partial beats, and do not pulse dfp_resp.

Test Plan:
- Read, ready always high, addr 0x0000_1234 → bmem_addr=0x0000_1220 and bmem_read for 1 cycle. Beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 → dfp_rdata={0x44..,0x33..,0x22..,0x11..} and one dfp_resp pulse the cycle after the 4th beat.
- Write of line 0xDDDD..CCCC..BBBB..AAAA to 0x8000_0040, ready always high → four consecutive bmem_write beats 0xAAAA.., 0xBBBB.., 0xCCCC.., 0xDDDD.. at addr 0x8000_0040, then dfp_resp at cycle 5.
- Write with bmem_ready low on beat 2 for 3 cycles → beat 2 data held unchanged; total 4 beats; dfp_resp delayed by 3 cycles.
- dfp_read and dfp_write both high, write addr 0x100, read addr 0x200 → write burst with dfp_resp, then read command to 0x200, then a second dfp_resp. No overlap of bmem_read and bmem_write.
- Read with an interleaved rvalid beat carrying raddr 0xDEAD_BEE0 → that beat is ignored; the line is assembled only from matching beats.
- rst asserted after 2 read beats → outputs 0 next cycle and no dfp_resp. A new read then completes normally with a fresh line.
